// File: rtl/pingpang_pkg.sv
// Shared definitions for the ping-pong read-stream checker.
package pingpang_pkg;

  // Last byte value of the generator sequence; must be odd so words pair up.
  localparam int unsigned MAX_VAL = 99;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Low byte expected in the word after one whose low byte is lo.
  // max_v is the sequence's last byte, so the last low byte is max_v-1.
  function automatic logic [7:0] next_lo(input logic [7:0] lo, input logic [7:0] max_v);
    if (lo == max_v - 8'd1) begin
      next_lo = 8'd0;
    end else begin
      next_lo = lo + 8'd2;
    end
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear beats increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pingpang_rx_check.sv
// Checker for the ping-pong controller read stream: locks onto the
// 0..MAX_VAL byte pattern (two bytes per word, low byte first) and reports
// errors, counters and the first bad word.
//
// state  | meaning
// SYNC   | hunting: counting consecutive in-sequence consistent words
// LOCKED | tracking: every valid word is compared with the expected word
module pingpang_rx_check
  import pingpang_pkg::*;
#(
  parameter int unsigned MAX_VAL   = pingpang_pkg::MAX_VAL,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        data_valid,
  input  logic [15:0] data_out,
  input  logic        cnt_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] word_cnt,
  output logic [15:0] first_bad,
  output logic        bad_seen
);

  localparam logic [7:0] MAX_B   = 8'(MAX_VAL);
  localparam logic [7:0] LAST_LO = 8'(MAX_VAL - 1);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_N  = 4'(ERR_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  exp_lo_q, exp_lo_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic        err_pulse_q, err_pulse_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] first_bad_q, first_bad_d;
  logic        bad_seen_q, bad_seen_d;

  logic [7:0]  lo, hi;
  logic        word_ok;
  logic        mismatch;
  logic [3:0]  match_next;
  logic [3:0]  miss_next;

  assign lo       = data_out[7:0];
  assign hi       = data_out[15:8];
  assign word_ok  = ~lo[0] && (lo <= LAST_LO) && (hi == lo + 8'd1);
  assign mismatch = data_valid && (state_q == LOCKED) &&
                    (data_out != {exp_lo_q + 8'd1, exp_lo_q});

  // Next-state logic: sync hunting, lock tracking and error pulse.
  always_comb begin
    state_d     = state_q;
    exp_lo_d    = exp_lo_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    match_next  = 4'd0;
    miss_next   = miss_cnt_q + 4'd1;
    case (state_q)
      SYNC: begin
        if (data_valid) begin
          if (word_ok) begin
            exp_lo_d = next_lo(lo, MAX_B);
            // An out-of-order but consistent word restarts the run from itself.
            if ((match_cnt_q == 4'd0) || (lo == exp_lo_q)) begin
              match_next = match_cnt_q + 4'd1;
            end else begin
              match_next = 4'd1;
            end
            if (match_next >= LOCK_N) begin
              state_d     = LOCKED;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end else begin
              match_cnt_d = match_next;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (data_valid) begin
          // Advance even on a mismatch so a single glitched word costs one error.
          exp_lo_d = next_lo(exp_lo_q, MAX_B);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (miss_next >= MISS_N) begin
              state_d     = SYNC;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end else begin
              miss_cnt_d = miss_next;
            end
          end else begin
            miss_cnt_d = 4'd0;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Word counter and first-bad capture; clear takes priority over update.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    first_bad_d = first_bad_q;
    bad_seen_d  = bad_seen_q;
    if (cnt_clr) begin
      word_cnt_d  = 32'd0;
      first_bad_d = 16'd0;
      bad_seen_d  = 1'b0;
    end else begin
      if (data_valid) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end
      if (mismatch && !bad_seen_q) begin
        first_bad_d = data_out;
        bad_seen_d  = 1'b1;
      end
    end
  end

  // State and status registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= SYNC;
      exp_lo_q    <= 8'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_pulse_q <= 1'b0;
      word_cnt_q  <= 32'd0;
      first_bad_q <= 16'd0;
      bad_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_lo_q    <= exp_lo_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      word_cnt_q  <= word_cnt_d;
      first_bad_q <= first_bad_d;
      bad_seen_q  <= bad_seen_d;
    end
  end

  sat_cnt #(.WIDTH(16)) u_err_cnt (
    .clk (sys_clk),
    .rst (sys_rst),
    .clr (cnt_clr),
    .inc (mismatch),
    .cnt (err_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign word_cnt  = word_cnt_q;
  assign first_bad = first_bad_q;
  assign bad_seen  = bad_seen_q;

endmodule

// File: doc/pingpang_rx_check.md
Name: pingpang_rx_check

Overview:
- Downstream consumer of the ping-pong RAM controller's 16-bit read stream, on the read-side clock domain.
- Checks that the stream matches the data generator's pattern: bytes 0..MAX_VAL cycling, packed two per word.
- Reports lock status, error pulses and counters, and captures the first bad word, so the buffer can be checked on board and in simulation.

Parameters:
- MAX_VAL, 99, last byte value of the generator sequence; must be odd; the sequence wraps to 0 after it.
- LOCK_CNT, 4, consecutive matching words required to declare lock (1..15).
- ERR_LIMIT, 3, consecutive mismatches in LOCKED that force return to SYNC (1..15).

Ports:
- sys_clk  in  1  read-side clock (25 MHz in the ping-pong system).
- sys_rst  in  1  synchronous reset, active-high.
- data_valid  in  1  data_out word is valid this cycle.
- data_out  in  16  word from ping-pong controller; {hi byte, lo byte}, lo is the earlier byte.
- cnt_clr  in  1  synchronous clear of the counters and capture register; does not change state.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word in LOCKED.
- err_cnt  out  16  saturating mismatch count; holds at 16'hFFFF.
- word_cnt  out  32  count of valid words received in any state; wraps.
- first_bad  out  16  first mismatching word since reset or cnt_clr.
- bad_seen  out  1  first_bad holds a valid capture.

Behaviour:
- One clock (sys_clk); reset is synchronous and active-high (sys_rst).
- Reset values: state=SYNC, locked=0, err_pulse=0, err_cnt=0, word_cnt=0, first_bad=0, bad_seen=0, exp_lo=0, match_cnt=0, miss_cnt=0.
- Reset mid-stream wins over everything in that cycle.
- Word is consistent iff lo is even, lo <= MAX_VAL-1, and hi == lo+1 (8-bit compare).
- Expected-next rule: exp_lo becomes lo+2, or 0 when lo == MAX_VAL-1.
- All outputs are registered: a word sampled on edge N affects outputs visible after edge N (latency 1).
- Cycles with data_valid=0 change nothing; gaps of any length are legal.

State SYNC:
- Valid consistent word with match_cnt==0, or with lo==exp_lo: match_cnt+1 and exp_lo = next(lo).
- Reaching LOCK_CNT: go to LOCKED, set match_cnt=0 and miss_cnt=0.
- Valid word that is consistent but lo!=exp_lo: match_cnt=1, exp_lo = next(lo). This restarts from the new word.
- Inconsistent word: match_cnt=0.
- No errors are counted in SYNC.

State LOCKED:
- Valid word == {exp_lo+1, exp_lo}: exp_lo advances, miss_cnt=0.
- Mismatch: err_pulse=1 next cycle, err_cnt+1 (saturating), exp_lo still advances (treated as a single-word glitch), miss_cnt+1.
- On a mismatch with bad_seen=0: capture first_bad and set bad_seen=1.
- When miss_cnt reaches ERR_LIMIT: go to SYNC, set match_cnt=0; locked falls on the same edge.

Other rules:
- word_cnt increments on every valid word.
- cnt_clr clears err_cnt, word_cnt, first_bad and bad_seen. It takes priority over an increment in the same cycle: the counter result is 0, not 1.
- err_pulse is still generated in a cnt_clr cycle.

Decomposition:
- Shared package pingpang_pkg holds MAX_VAL, the state encoding (SYNC, LOCKED), and the word-packing helper function next_lo().
- One natural sub-module: sat_cnt (width-parameterised saturating counter with clear), used for err_cnt.
- Everything else is inline.

Test Plan:
- Reset, then 4 valid words 16'h0100, 16'h0302, 16'h0504, 16'h0706 -> locked=1 after the 4th edge; err_cnt=0; word_cnt=4.
- Locked stream, then inject 16'h0908 replaced by 16'h09FF -> one err_pulse; err_cnt=1; first_bad=16'h09FF; bad_seen=1; next word 16'h0B0A accepted with no error; locked stays 1.
- Wrap: locked, feed 16'h6362 (98,99) then 16'h0100 -> no error. Feeding 16'h6564 instead -> inconsistent, err_pulse.
- 3 consecutive bad words in LOCKED -> locked drops on the 3rd; err_cnt=3; 4 good words from 16'h1110 relock.
- Valid gaps: alternate data_valid 1/0 over 20 cycles of a correct stream -> no errors, word_cnt=10. Then sys_rst asserted for one cycle mid-stream -> all outputs 0 and state=SYNC on the next edge.
- cnt_clr asserted in the same cycle as a mismatch with err_cnt=5 -> err_cnt=0, bad_seen=0, err_pulse=1.
